// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_if
//  Description : Pipeline-side and memory-side signal bundle of the L1 data
//                cache controller. The slave modport is the cache; the master
//                modport is the processor/memory environment around it.
//  Revision    : 1.0  initial release
// ============================================================================
interface dcache_ctrl_if;
    // Processor side (EX/MEM pipeline register)
    logic         p_read_i;
    logic         p_write_i;
    logic [31:0]  p_addr_i;
    logic [31:0]  p_wdata_i;
    logic [31:0]  p_rdata_o;
    logic         p_stall_o;

    // Memory side (line-granular request/acknowledge port)
    logic         m_req_o;
    logic         m_we_o;
    logic [31:0]  m_addr_o;
    logic [255:0] m_wdata_o;
    logic [255:0] m_rdata_i;
    logic         m_ack_i;

    modport slave (
        input  p_read_i, p_write_i, p_addr_i, p_wdata_i,
        output p_rdata_o, p_stall_o,
        output m_req_o, m_we_o, m_addr_o, m_wdata_o,
        input  m_rdata_i, m_ack_i
    );

    modport master (
        output p_read_i, p_write_i, p_addr_i, p_wdata_i,
        input  p_rdata_o, p_stall_o,
        input  m_req_o, m_we_o, m_addr_o, m_wdata_o,
        output m_rdata_i, m_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate L1 data cache
//                controller for the MEM stage. Hits complete with no stall;
//                misses write back a dirty victim, then refill the line over
//                a request/acknowledge port while stalling the pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    dcache_ctrl_if.slave     bus
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 27 - IDX;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    // Storage arrays
    logic [255:0]     r_data [LINES];
    logic [TAGW-1:0]  r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;

    // Controller state and registered memory-port outputs
    state_t           r_state;
    logic             r_m_req;
    logic             r_m_we;
    logic [31:0]      r_m_addr;
    logic [255:0]     r_m_wdata;

    // Miss request captured at the IDLE miss, so the refill completes even
    // if the access is dropped mid-miss
    logic [IDX-1:0]   r_miss_idx;
    logic [TAGW-1:0]  r_miss_tag;

    // Address decode
    logic [2:0]       w_word;
    logic [IDX-1:0]   w_idx;
    logic [TAGW-1:0]  w_tag;
    logic             w_unused_addr_lsb;

    assign w_word            = bus.p_addr_i[4:2];
    assign w_idx             = bus.p_addr_i[4+IDX:5];
    assign w_tag             = bus.p_addr_i[31:5+IDX];
    assign w_unused_addr_lsb = ^bus.p_addr_i[1:0];

    // Lookup
    logic [255:0]     w_line;
    logic [31:0]      w_word_data;
    logic             w_access;
    logic             w_hit;
    logic             w_idle;
    logic             w_store_hit;
    logic             w_refill_done;
    logic             w_victim_dirty;
    logic [31:0]      w_victim_addr;
    logic [31:0]      w_req_addr;
    logic [31:0]      w_refill_addr;

    assign w_line         = r_data[w_idx];
    assign w_word_data    = w_line[{w_word, 5'b0} +: 32];
    assign w_access       = bus.p_read_i | bus.p_write_i;
    assign w_hit          = w_access & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_idle         = (r_state == S_IDLE);
    assign w_store_hit    = w_idle & w_hit & bus.p_write_i;
    assign w_refill_done  = (r_state == S_REFILL) & bus.m_ack_i;
    assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
    assign w_victim_addr  = {r_tag[w_idx], w_idx, 5'b0};
    assign w_req_addr     = {w_tag, w_idx, 5'b0};
    assign w_refill_addr  = {r_miss_tag, r_miss_idx, 5'b0};

    // Miss sequencer: picks WB or REFILL on an IDLE miss, holds the memory
    // request until its ack, and maintains valid/dirty bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_dirty   <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        if (bus.p_write_i) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end else if (w_access) begin
                        r_miss_idx <= w_idx;
                        r_miss_tag <= w_tag;
                        r_m_req    <= 1'b1;
                        if (w_victim_dirty) begin
                            r_state   <= S_WB;
                            r_m_we    <= 1'b1;
                            r_m_addr  <= w_victim_addr;
                            r_m_wdata <= w_line;
                        end else begin
                            r_state   <= S_REFILL;
                            r_m_we    <= 1'b0;
                            r_m_addr  <= w_req_addr;
                            r_m_wdata <= '0;
                        end
                    end
                end
                S_WB: begin
                    // Go straight into the refill request: no idle gap
                    if (bus.m_ack_i) begin
                        r_state   <= S_REFILL;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= w_refill_addr;
                        r_m_wdata <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.m_ack_i) begin
                        r_state               <= S_IDLE;
                        r_valid[r_miss_idx]   <= 1'b1;
                        r_dirty[r_miss_idx]   <= 1'b0;
                        r_m_req               <= 1'b0;
                        r_m_we                <= 1'b0;
                        r_m_addr              <= '0;
                        r_m_wdata             <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_m_req   <= 1'b0;
                    r_m_we    <= 1'b0;
                    r_m_addr  <= '0;
                    r_m_wdata <= '0;
                end
            endcase
        end
    end

    // Data and tag arrays: store-hit word writes and refill line installs;
    // no reset because valid bits qualify their contents
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_store_hit) begin
                r_data[w_idx][{w_word, 5'b0} +: 32] <= bus.p_wdata_i;
            end
            if (w_refill_done) begin
                r_data[r_miss_idx] <= bus.m_rdata_i;
                r_tag[r_miss_idx]  <= r_miss_tag;
            end
        end
    end

    // Pipeline-facing outputs are combinational so hits cost no cycle
    assign bus.p_rdata_o = (w_idle && bus.p_read_i && w_hit) ? w_word_data : 32'd0;
    assign bus.p_stall_o = (r_state == S_WB) | (r_state == S_REFILL) |
                           (w_idle & w_access & ~w_hit);

    assign bus.m_req_o   = r_m_req;
    assign bus.m_we_o    = r_m_we;
    assign bus.m_addr_o  = r_m_addr;
    assign bus.m_wdata_o = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl: line-level cache and
//                memory model with an expected-transaction queue, a memory
//                responder with programmable ack latency, and directed tests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

    logic clk;
    logic rst;

    dcache_ctrl_if bus();

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    logic [255:0] mem [int];

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  w;
        if (mem.exists(int'(a))) return mem[int'(a)];
        for (int k = 0; k < 8; k++) begin
            w = 32'hC0DE_0000 | (a + 32'(4 * k));
            l[k*32 +: 32] = w;
        end
        return l;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t         q[$];
    bit           mv [32];
    bit           md [32];
    logic [21:0]  mt [32];
    logic [255:0] ml [32];
    bit           started = 1'b0;

    logic [31:0]  ma;
    logic [4:0]   mi;
    txn_t         mtx;

    // Model update at each rising edge from the (stable) inputs
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                mv[k] = 1'b0;
                md[k] = 1'b0;
            end
            q.delete();
            started = 1'b1;
        end else if (started) begin
            if (q.size() != 0) begin
                if (bus.m_ack_i) begin
                    mtx = q.pop_front();
                    if (mtx.we) begin
                        mem[int'(mtx.addr)] = mtx.data;
                    end else begin
                        mi     = mtx.addr[9:5];
                        ml[mi] = mem_line(mtx.addr);
                        mt[mi] = mtx.addr[31:10];
                        mv[mi] = 1'b1;
                        md[mi] = 1'b0;
                    end
                end
            end else if (bus.p_read_i || bus.p_write_i) begin
                ma = bus.p_addr_i;
                mi = ma[9:5];
                if (mv[mi] && mt[mi] == ma[31:10]) begin
                    if (bus.p_write_i) begin
                        ml[mi][ma[4:2]*32 +: 32] = bus.p_wdata_i;
                        md[mi] = 1'b1;
                    end
                end else begin
                    if (mv[mi] && md[mi])
                        q.push_back(txn_t'{1'b1, {mt[mi], mi, 5'b0}, ml[mi]});
                    q.push_back(txn_t'{1'b0, {ma[31:5], 5'b0}, 256'd0});
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    logic [31:0]  ca;
    logic [4:0]   ci;
    bit           chit;
    logic         e_req, e_we, e_stall;
    logic [31:0]  e_addr, e_rd;
    logic [255:0] e_wd;

    initial forever begin
        @(negedge clk);
        if (started) begin
            if (q.size() != 0) begin
                e_req   = 1'b1;
                e_we    = q[0].we;
                e_addr  = q[0].addr;
                e_wd    = q[0].we ? q[0].data : 256'd0;
                e_stall = 1'b1;
                e_rd    = 32'd0;
            end else begin
                ca      = bus.p_addr_i;
                ci      = ca[9:5];
                chit    = (bus.p_read_i || bus.p_write_i) && mv[ci] && (mt[ci] == ca[31:10]);
                e_req   = 1'b0;
                e_we    = 1'b0;
                e_addr  = 32'd0;
                e_wd    = 256'd0;
                e_stall = (bus.p_read_i || bus.p_write_i) && !chit;
                e_rd    = (bus.p_read_i && chit) ? ml[ci][ca[4:2]*32 +: 32] : 32'd0;
            end
            chk("cyc_stall", bus.p_stall_o, e_stall);
            chk("cyc_rdata", bus.p_rdata_o, e_rd);
            chk("cyc_req",   bus.m_req_o,   e_req);
            chk("cyc_we",    bus.m_we_o,    e_we);
            chk("cyc_addr",  bus.m_addr_o,  e_addr);
            chk("cyc_wdata", bus.m_wdata_o, e_wd);
        end
    end

    // ---------------- memory responder ----------------
    int ack_delay = 2;
    int rcnt      = 0;
    bit spur      = 1'b0;
    bit rack;

    // Acks after ack_delay request cycles; drives at +2 to stay clear of
    // the stimulus process at +1
    initial begin
        bus.m_ack_i   = 1'b0;
        bus.m_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            rack = 1'b0;
            if (bus.m_req_o === 1'b1) begin
                rcnt++;
                if (rcnt >= ack_delay) begin
                    rack = 1'b1;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
            bus.m_ack_i   = rack | spur;
            bus.m_rdata_i = (bus.m_req_o === 1'b1 && bus.m_we_o === 1'b0) ?
                            mem_line(bus.m_addr_o) : '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit at_neg, output int stalls, output bit wb,
                             output logic [31:0] wb_addr, output logic [255:0] wb_data,
                             output logic [31:0] rf_addr, output logic [31:0] rdata);
        stalls  = 0;
        wb      = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        rf_addr = '0;
        if (!at_neg) @(negedge clk);
        while (bus.p_stall_o === 1'b1 && stalls < 60) begin
            stalls++;
            if (bus.m_req_o === 1'b1) begin
                if (bus.m_we_o === 1'b1) begin
                    wb      = 1'b1;
                    wb_addr = bus.m_addr_o;
                    wb_data = bus.m_wdata_o;
                end else begin
                    rf_addr = bus.m_addr_o;
                end
            end
            @(negedge clk);
        end
        if (stalls >= 60) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got %0d stall cycles expected completion", stalls);
        end
        rdata = bus.p_rdata_o;
        cyc();
    endtask

    int           n_st;
    bit           s_wb;
    logic [31:0]  s_wba, s_rfa, s_rd;
    logic [255:0] s_wbd;
    logic [255:0] tmp_line;

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.p_read_i  = rd;
        bus.p_write_i = wr;
        bus.p_addr_i  = a;
        bus.p_wdata_i = d;
        wait_done(1'b0, n_st, s_wb, s_wba, s_wbd, s_rfa, s_rd);
        bus.p_read_i  = 1'b0;
        bus.p_write_i = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst           = 1'b1;
        bus.p_read_i  = 1'b0;
        bus.p_write_i = 1'b0;
        bus.p_addr_i  = '0;
        bus.p_wdata_i = '0;
        tmp_line         = mem_line(32'h40);
        tmp_line[31:0]   = 32'hDEADBEEF;
        mem[32'h40]      = tmp_line;

        repeat (3) cyc();
        chk("rst_req",   bus.m_req_o,   1'b0);
        chk("rst_we",    bus.m_we_o,    1'b0);
        chk("rst_addr",  bus.m_addr_o,  32'd0);
        chk("rst_wdata", bus.m_wdata_o, 256'd0);
        chk("rst_stall", bus.p_stall_o, 1'b0);
        chk("rst_rdata", bus.p_rdata_o, 32'd0);
        rst = 1'b0;
        cyc();

        // 1: cold read miss, ack in 2nd REFILL cycle
        ack_delay = 2;
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        chk("t1_stalls", 32'(n_st), 32'd3);
        chk("t1_no_wb",  s_wb,      1'b0);
        chk("t1_rfaddr", s_rfa,     32'h40);
        chk("t1_rdata",  s_rd,      32'hDEADBEEF);

        // 2: write hit then read-back
        ack_delay = 1;
        do_access(1'b0, 1'b1, 32'h44, 32'h1234_5678);
        chk("t2_wr_stalls", 32'(n_st), 32'd0);
        do_access(1'b1, 1'b0, 32'h44, 32'h0);
        chk("t2_rd_stalls", 32'(n_st), 32'd0);
        chk("t2_rdata",     s_rd,      32'h1234_5678);

        // 3: dirty conflict, W=2 R=2
        ack_delay = 2;
        do_access(1'b1, 1'b0, 32'h440, 32'h0);
        chk("t3_stalls", 32'(n_st),     32'd5);
        chk("t3_wb",     s_wb,          1'b1);
        chk("t3_wbaddr", s_wba,         32'h40);
        chk("t3_wbword", s_wbd[63:32],  32'h1234_5678);
        chk("t3_rfaddr", s_rfa,         32'h440);
        chk("t3_rdata",  s_rd,          32'hC0DE_0440);

        // 4: clean conflict, refill only
        ack_delay = 1;
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        chk("t4_stalls", 32'(n_st), 32'd2);
        chk("t4_no_wb",  s_wb,      1'b0);
        chk("t4_rfaddr", s_rfa,     32'h40);
        chk("t4_rdata",  s_rd,      32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h44, 32'h0);
        chk("t4_wb_roundtrip", s_rd, 32'h1234_5678);

        // 5: stray ack with no access
        spur = 1'b1;
        @(negedge clk);
        chk("t5_ack_seen", bus.m_ack_i,   1'b1);
        chk("t5_req",      bus.m_req_o,   1'b0);
        chk("t5_stall",    bus.p_stall_o, 1'b0);
        cyc();
        spur = 1'b0;
        cyc();
        do_access(1'b1, 1'b0, 32'h44, 32'h0);
        chk("t5_hit_stalls", 32'(n_st), 32'd0);
        chk("t5_hit_rdata",  s_rd,      32'h1234_5678);

        // 6: reset in the 2nd REFILL cycle, then refill again normally
        ack_delay = 3;
        bus.p_read_i = 1'b1;
        bus.p_addr_i = 32'h840;
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_req_before_rst", bus.m_req_o, 1'b1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_req_dropped", bus.m_req_o,   1'b0);
        chk("t6_miss_again",  bus.p_stall_o, 1'b1);
        wait_done(1'b1, n_st, s_wb, s_wba, s_wbd, s_rfa, s_rd);
        bus.p_read_i = 1'b0;
        chk("t6_stalls", 32'(n_st), 32'd4);
        chk("t6_no_wb",  s_wb,      1'b0);
        chk("t6_rfaddr", s_rfa,     32'h840);
        chk("t6_rdata",  s_rd,      32'hC0DE_0840);
        do_access(1'b1, 1'b0, 32'h840, 32'h0);
        chk("t6_hit_stalls", 32'(n_st), 32'd0);
        chk("t6_hit_rdata",  s_rd,      32'hC0DE_0840);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data-cache controller for the MEM stage. It takes load/store requests from the EX/MEM pipeline register (MemRead, MemWrite, ALU result as address, RS2 data as store data) and serves hits in zero extra cycles. On a miss it sequences victim write-back and line refill over a request/acknowledge memory port. While a miss is in progress it drives `p_stall_o`, which feeds the `mem_stall_i` input of the pipeline registers and freezes them.

## Interface
- `LINES`, 32: number of cache lines; must be a power of 2. `IDX = log2(LINES)`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `p_read_i`  in  1  load request (EX/MEM MemRead).
- `p_write_i`  in  1  store request (EX/MEM MemWrite).
- `p_addr_i`  in  32  byte address (EX/MEM ALU result).
- `p_wdata_i`  in  32  store data (EX/MEM RS2 data).
- `p_rdata_o`  out  32  load data; valid in the cycle of a read hit.
- `p_stall_o`  out  1  stall for the pipeline registers and PC.
- `m_req_o`  out  1  memory request.
- `m_we_o`  out  1  1 = line write (write-back), 0 = line read (refill).
- `m_addr_o`  out  32  line-aligned memory address; bits [4:0] are 0.
- `m_wdata_o`  out  256  write-back line data.
- `m_rdata_i`  in  256  refill line data; sampled when `m_ack_i` is high in REFILL.
- `m_ack_i`  in  1  memory completion; one-cycle pulse.

## Operation
- **Address split:**
  - word = `addr[4:2]`
  - index = `addr[4+IDX:5]`
  - tag = `addr[31:5+IDX]` (22 bits at LINES=32)
  - `addr[1:0]` is ignored; accesses are word-only.
- **Internal storage per line:** 256-bit data, tag, valid, dirty.
- **Access:** `p_read_i | p_write_i`. If both are high, the access is a store, and read data is still driven.
- **Hit:** access && `valid[index]` && tag match.
- **IDLE:**
  - Read hit: `p_rdata_o` = selected word, combinationally, same cycle.
  - Write hit: at the edge, the word is written and `dirty[index]` is set to 1.
  - Miss: `p_stall_o` = 1 combinationally. Next state is WB if the victim is valid and dirty, otherwise REFILL.
- **WB:**
  - `m_req_o` = 1, `m_we_o` = 1.
  - `m_addr_o` = {victim tag, index, 5'b0}; `m_wdata_o` = victim line.
  - On `m_ack_i`: go to REFILL.
- **REFILL:**
  - `m_req_o` = 1, `m_we_o` = 0.
  - `m_addr_o` = {req tag, index, 5'b0}.
  - On `m_ack_i`: line ← `m_rdata_i`, tag ← req tag, valid ← 1, dirty ← 0; go to IDLE.
  - Back in IDLE, the held request hits and completes (a store then sets dirty).
- **Stall:** `p_stall_o` = 1 in WB, in REFILL, and on an IDLE miss. Otherwise 0.
- **Idle outputs:** `p_rdata_o` = 0 when there is no read hit. `m_*` outputs are 0 when not requesting.
- **Input stability:** the processor holds its inputs while `p_stall_o` = 1, because the pipeline is frozen. If the access deasserts mid-miss, the transaction still completes; there is no abort.
- **Stray acks:** `m_ack_i` outside WB/REFILL is ignored.

## Timing
- **Reset:** in any state, at the edge with `rst_i` = 1, the controller enters IDLE and clears all valid and dirty bits. Data and tag arrays are don't-care.
- **Outputs after reset:** `m_req_o` = 0, `m_we_o` = 0, `m_addr_o` = 0, `m_wdata_o` = 0, `p_stall_o` = 0, `p_rdata_o` = 0 (no access).
- **Reset mid-transaction:** a reset during WB or REFILL drops `m_req_o` the cycle after the reset edge. A partial refill is not installed.
- **Hit latency:** 0 stall cycles.
- **Clean-miss stall:** 1 + R cycles, where R is the number of REFILL cycles up to and including the ack cycle. The minimum is 2 (ack in the first REFILL cycle).
- **Dirty-miss stall:** 1 + W + R cycles, where W is the number of WB cycles including the ack cycle.
- **Request hold:** `m_req_o`, `m_we_o`, `m_addr_o` and `m_wdata_o` are stable from entering the state until the ack edge. `m_req_o` falls the cycle after the ack. There is no idle gap between WB and REFILL.
- **State encoding:** 2-bit state, IDLE = 0, WB = 1, REFILL = 2. State 3 goes to IDLE.

## Test plan
1. **Cold read miss:** after reset, read 0x0000_0040; memory acks on the 2nd REFILL cycle with word0 = 0xDEADBEEF.
   - `m_addr_o` = 0x40, `m_we_o` = 0, no WB.
   - `p_stall_o` high for 3 cycles, then `p_rdata_o` = 0xDEADBEEF with stall = 0.
2. **Write hit:** write 0x44 with data 0x1234_5678.
   - No stall, no `m_req_o`.
   - A following read of 0x44 returns 0x1234_5678 in the same cycle.
3. **Dirty conflict:** read 0x0000_0440 (same index 2, different tag).
   - WB with `m_we_o` = 1, `m_addr_o` = 0x40, `m_wdata_o[63:32]` = 0x1234_5678.
   - Then REFILL with `m_addr_o` = 0x440.
   - Stall = 1 + W + R cycles.
4. **Clean conflict:** read 0x40 again after scenario 3 (line 0x440 is clean).
   - No WB; REFILL only, `m_addr_o` = 0x40.
5. **Spurious ack / no access:** pulse `m_ack_i` in IDLE with no access.
   - `m_req_o` stays 0, `p_stall_o` stays 0, state is unchanged.
6. **Reset mid-refill:** assert `rst_i` in the 2nd REFILL cycle.
   - `m_req_o` = 0 the next cycle.
   - A re-read of the same address misses (valid was cleared) and refills normally.
